ntt_wb_sched: RTL and testbench

Write-back scheduler for the NTT memory, sitting at the far end of the NTT index generator.
- Accepts each butterfly read issued by the index generator (addresses a/b, point-mul flag, last flag) and delays it through a shift register matching the butterfly pipeline depth.
- Emits the matching write-enable/address strobes when the results leave the arithmetic unit.
- Optionally raises a stall when a new read targets a coefficient whose write-back is still pending, e.g. across layer boundaries or the forward→inverse turnaround.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ntt_wb_sched_if.sv | 30 +++
 rtl/ntt_wb_delay_line.sv | 21 ++
 rtl/ntt_wb_sched.sv | 108 ++++++++++
 tb/tb_ntt_wb_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants and the write-back scheduler entry type.
package ntt_pkg;

    localparam int AW      = 11;
    localparam int N_LARGE = 2048;
    localparam int N_SMALL = 1024;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          pm;
        logic          last;
    } wb_entry_t;

endpackage

// File: rtl/ntt_wb_sched_if.sv
// Read-side and write-side signals of the NTT write-back scheduler.
interface ntt_wb_sched_if import ntt_pkg::*;;

    // Handshake: a read transfers in a cycle where rd_valid is high and stall is
    // low; stall acts as an inverted ready and is combinational from rd_*.
    logic          rd_valid;
    logic [AW-1:0] rd_index_a;
    logic [AW-1:0] rd_index_b;
    logic          rd_point_mul;
    logic          rd_last;
    logic          stall;
    logic          wr_en_a;
    logic          wr_en_b;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic          wr_last;
    logic          busy;
    logic          drop_err;

    modport master (
        output rd_valid, rd_index_a, rd_index_b, rd_point_mul, rd_last,
        input  stall, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_last, busy, drop_err
    );

    modport slave (
        input  rd_valid, rd_index_a, rd_index_b, rd_point_mul, rd_last,
        output stall, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_last, busy, drop_err
    );

endinterface

// File: rtl/ntt_wb_delay_line.sv
// Shift register of write-back entries with synchronous clear; every stage is
// exposed so the top level can compare pending write addresses.
module ntt_wb_delay_line import ntt_pkg::*; #(
    parameter int DEPTH = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  wb_entry_t din,
    output wb_entry_t stage [DEPTH]
);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= din;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

endmodule

// File: rtl/ntt_wb_sched.sv
// NTT write-back scheduler: delays accepted butterfly reads by LATENCY cycles
// and emits write strobes. Define NTT_WB_HAZARD_EN to build the read/write hazard stall.
module ntt_wb_sched import ntt_pkg::*; #(
    parameter int LATENCY = 6
) (
    input  logic           clk,
    input  logic           rst,
    ntt_wb_sched_if.slave  bus
);

    // Stages 0..LATENCY-2 live in the delay line; the output register is the
    // final stage, so an accept at t writes at t+LATENCY.
    localparam int DEPTH = LATENCY - 1;
    localparam int CW    = $clog2(LATENCY + 1);

    wb_entry_t     stage [DEPTH];
    wb_entry_t     din;
    wb_entry_t     tail;
    logic          accept;
    logic          wr_en_a_q, wr_en_b_q, wr_last_q;
    logic [AW-1:0] wr_addr_a_q, wr_addr_b_q;
    logic [CW-1:0] count_q;

    assign accept = bus.rd_valid && !bus.stall;
    assign tail   = stage[DEPTH-1];

    always_comb begin
        din       = '0;
        din.valid = accept;
        din.a     = bus.rd_index_a;
        din.b     = bus.rd_index_b;
        din.pm    = bus.rd_point_mul;
        din.last  = bus.rd_last;
    end

    ntt_wb_delay_line #(.DEPTH(DEPTH)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .stage (stage)
    );

`ifdef NTT_WB_HAZARD_EN
    logic hazard;
    logic drop_q;

    // The output register is excluded: memory commits that entry this cycle.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage[k].valid) begin
                if (stage[k].a == bus.rd_index_a ||
                    (!bus.rd_point_mul && stage[k].a == bus.rd_index_b))
                    hazard = 1'b1;
                if (!stage[k].pm &&
                    (stage[k].b == bus.rd_index_a ||
                     (!bus.rd_point_mul && stage[k].b == bus.rd_index_b)))
                    hazard = 1'b1;
            end
        end
    end

    assign bus.stall = bus.rd_valid && hazard && !rst;

    always_ff @(posedge clk) begin
        if (rst)                            drop_q <= 1'b0;
        else if (bus.rd_valid && bus.stall) drop_q <= 1'b1;
    end

    assign bus.drop_err = drop_q;
`else
    assign bus.stall    = 1'b0;
    assign bus.drop_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_a_q   <= 1'b0;
            wr_en_b_q   <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            count_q     <= '0;
        end else begin
            wr_en_a_q <= tail.valid;
            wr_en_b_q <= tail.valid && !tail.pm;
            wr_last_q <= tail.valid && tail.last;
            if (tail.valid) begin
                wr_addr_a_q <= tail.a;
                wr_addr_b_q <= tail.b;
            end
            // Retirement is counted when the entry sits in the output register.
            case ({accept, wr_en_a_q})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.wr_en_a   = wr_en_a_q;
    assign bus.wr_en_b   = wr_en_b_q;
    assign bus.wr_last   = wr_last_q;
    assign bus.wr_addr_a = wr_addr_a_q;
    assign bus.wr_addr_b = wr_addr_b_q;
    assign bus.busy      = (count_q != '0);

endmodule

// File: tb/tb_ntt_wb_sched.sv
// Bench for ntt_wb_sched: directed scenarios then random traffic, checked every
// cycle against a timestamp-based model of in-flight reads. Honours NTT_WB_HAZARD_EN.
`timescale 1ns/1ps
module tb_ntt_wb_sched;
  import ntt_pkg::*;

  localparam int L = 6;
`ifdef NTT_WB_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_wb_sched_if bus ();

  ntt_wb_sched #(.LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog cyc_limit_exceeded observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference model: accepted reads with their accept cycle
  typedef struct {
    int            t;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    bit            pm;
    bit            last;
  } ent_t;

  ent_t          infl[$];
  logic [AW-1:0] held_a = '0;
  logic [AW-1:0] held_b = '0;
  bit            drop_m = 1'b0;
  bit            m_acc  = 1'b0;
  int            cyc    = 0;
  int            last_wr_cyc = -1;
  int            tests  = 0;
  int            fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit conflict(ent_t e, logic [AW-1:0] a, logic [AW-1:0] b, bit pm);
    bit hit;
    hit = (e.a == a) || (!pm && e.a == b);
    if (!e.pm) hit = hit || (e.b == a) || (!pm && e.b == b);
    return hit;
  endfunction

  // One clock cycle: check at the falling edge, advance the model, step past the rising edge.
  task automatic tick();
    bit   es, found, eb;
    ent_t w;
    int   age;
    es = 1'b0; found = 1'b0; eb = 1'b0;
    w  = '{t: 0, a: '0, b: '0, pm: 1'b0, last: 1'b0};
    @(negedge clk);
    while (infl.size() > 0 && infl[0].t + L < cyc) void'(infl.pop_front());
    foreach (infl[i]) begin
      age = cyc - infl[i].t;
      if (age >= 1 && age <= L) eb = 1'b1;
      if (age == L) begin found = 1'b1; w = infl[i]; end
      if (HAZ && age >= 1 && age <= L - 1 &&
          conflict(infl[i], bus.rd_index_a, bus.rd_index_b, bus.rd_point_mul))
        es = 1'b1;
    end
    es = es && bus.rd_valid && !rst;
    if (found) begin held_a = w.a; held_b = w.b; end
    chk("stall",     32'(bus.stall),     32'(es));
    chk("wr_en_a",   32'(bus.wr_en_a),   32'(found));
    chk("wr_en_b",   32'(bus.wr_en_b),   32'(found && !w.pm));
    chk("wr_last",   32'(bus.wr_last),   32'(found && w.last));
    chk("wr_addr_a", 32'(bus.wr_addr_a), 32'(held_a));
    chk("wr_addr_b", 32'(bus.wr_addr_b), 32'(held_b));
    chk("busy",      32'(bus.busy),      32'(eb));
    chk("drop_err",  32'(bus.drop_err),  32'(drop_m));
    if (bus.wr_en_a === 1'b1) last_wr_cyc = cyc;
    m_acc = 1'b0;
    if (rst) begin
      infl.delete();
      held_a = '0; held_b = '0; drop_m = 1'b0;
    end else begin
      if (bus.rd_valid && es) drop_m = 1'b1;
      if (bus.rd_valid && !es) begin
        infl.push_back('{t: cyc, a: bus.rd_index_a, b: bus.rd_index_b,
                         pm: bus.rd_point_mul, last: bus.rd_last});
        m_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic idle(input int n);
    bus.rd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit pm,
                       input bit last, output int acc, output int stalls);
    stalls = 0;
    acc    = -1;
    bus.rd_valid = 1'b1; bus.rd_index_a = a; bus.rd_index_b = b;
    bus.rd_point_mul = pm; bus.rd_last = last;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_acc) begin acc = cyc - 1; break; end
      stalls++;
    end
    bus.rd_valid = 1'b0; bus.rd_last = 1'b0;
    chk("issue_accepted", 32'(acc >= 0), 32'd1);
  endtask

  initial begin
    int ta, tb, st, rc;
    bus.rd_valid = 1'b0; bus.rd_index_a = '0; bus.rd_index_b = '0;
    bus.rd_point_mul = 1'b0; bus.rd_last = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single butterfly at cycle 10
    while (cyc < 10) tick();
    issue(11'd5, 11'd261, 1'b0, 1'b0, ta, st);
    chk("single_acc_cyc", 32'(ta), 32'd10);
    idle(L + 2);
    chk("single_wr_cyc", 32'(last_wr_cyc), 32'd16);

    // point-multiply entry
    issue(11'd7, 11'd99, 1'b1, 1'b0, ta, st);
    idle(L + 2);
    chk("pm_wr_cyc", 32'(last_wr_cyc), 32'(ta + L));

    // read of a coefficient still awaiting write-back
    issue(11'd0, 11'd256, 1'b0, 1'b0, ta, st);
    issue(11'd256, 11'd300, 1'b0, 1'b0, tb, st);
    chk("haz_stalls",  32'(st), HAZ ? 32'(L - 1) : 32'd0);
    chk("haz_acc_cyc", 32'(tb), HAZ ? 32'(ta + L) : 32'(ta + 1));
    idle(L + 2);
    chk("haz_wr_cyc", 32'(last_wr_cyc), 32'(tb + L));
    chk("haz_drop_err", 32'(bus.drop_err), 32'(HAZ));

    // two-cycle reset mid-stream with three entries in flight
    issue(11'd20, 11'd21, 1'b0, 1'b0, ta, st);
    issue(11'd22, 11'd23, 1'b0, 1'b0, ta, st);
    issue(11'd24, 11'd25, 1'b1, 1'b0, ta, st);
    rc  = cyc;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle(L);
    chk("rst_no_write", 32'(last_wr_cyc < rc), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);

    // final read of the transform
    issue(11'd40, 11'd41, 1'b0, 1'b1, ta, st);
    idle(L + 2);
    chk("last_wr_cyc", 32'(last_wr_cyc), 32'(ta + L));

    // sticky drop error until reset
    issue(11'd50, 11'd51, 1'b0, 1'b0, ta, st);
    issue(11'd51, 11'd60, 1'b0, 1'b0, tb, st);
    idle(L + 4);
    chk("drop_sticky", 32'(bus.drop_err), 32'(HAZ));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    chk("drop_cleared", 32'(bus.drop_err), 32'd0);

    // random traffic over a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.rd_valid     = ($urandom_range(0, 3) != 0);
      bus.rd_index_a   = AW'($urandom_range(0, 31));
      bus.rd_index_b   = AW'($urandom_range(0, 31));
      bus.rd_point_mul = ($urandom_range(0, 3) == 0);
      bus.rd_last      = ($urandom_range(0, 15) == 0);
      rst              = (i == 200 || i == 201);
      tick();
    end
    rst = 1'b0;
    idle(L + 2);
    chk("end_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
